// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA scanline fetch path.
package vga_pkg;

  localparam int unsigned VgaWords  = 160;
  localparam int unsigned VgaStride = 640;
  localparam int unsigned VgaLnw    = 10;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_ISSUE = 2'd1;
  localparam fetch_state_t FS_DRAIN = 2'd2;
  localparam fetch_state_t FS_DONE  = 2'd3;

endpackage

// File: rtl/vga_linebuf.sv
// Ping-pong scanline buffer: write port on the system clock, registered read on the pixel clock.
module vga_linebuf #(
  parameter int unsigned WORDS = 160,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW:0]   wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          pix_clk,
  input  logic [AW:0]   rd_addr_i,
  output logic [31:0]   rd_data_o
);

  // Addressed as {bank, word}, so each bank occupies a full power-of-two slot.
  logic [31:0] mem_q [1 << (AW + 1)];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge pix_clk) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_line_fetch.sv
// Scanline fetcher: reads one line of pixel words over pipelined Wishbone into a ping-pong buffer.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned WORDS  = VgaWords,
  parameter int unsigned STRIDE = VgaStride,
  parameter int unsigned LNW    = VgaLnw
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pix_clk,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  input  logic [31:0]              base_addr,
  input  logic                     line_req,
  input  logic [LNW-1:0]           line_num,
  output logic                     busy,
  output logic                     line_ready,
  output logic                     fill_bank,
  output logic                     overrun,
  input  logic                     rd_bank,
  input  logic [$clog2(WORDS)-1:0] rd_addr,
  output logic [31:0]              rd_data
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned CW = AW + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic          fill_bank_q, fill_bank_d;
  logic          overrun_q, overrun_d;

  logic          in_cycle;
  logic          issue_take;
  logic          last_issue;
  logic          ack_take;
  logic [31:0]   adr_sum;

  always_comb begin
    in_cycle   = (state_q == FS_ISSUE) || (state_q == FS_DRAIN);
    issue_take = (state_q == FS_ISSUE) && !wb_stall_i;
    last_issue = issue_take && (issue_cnt_q == AW'(WORDS - 1));
    // Acks beyond a full line or outside a bus cycle never touch the buffer.
    ack_take   = in_cycle && wb_ack_i && (ack_cnt_q != CW'(WORDS));

    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    fill_bank_d = fill_bank_q;
    overrun_d   = overrun_q | (line_req && (state_q != FS_IDLE));

    if (ack_take) begin
      ack_cnt_d = ack_cnt_q + 1'b1;
    end
    if (issue_take && !last_issue) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
    end

    case (state_q)
      FS_IDLE: begin
        if (line_req) begin
          addr_d      = base_addr + (32'(line_num) * 32'(STRIDE));
          issue_cnt_d = '0;
          ack_cnt_d   = '0;
          state_d     = FS_ISSUE;
        end
      end
      FS_ISSUE: begin
        if (last_issue) begin
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        // Toggle on entry to DONE so line_ready already sees the new fill bank.
        if (ack_cnt_q == CW'(WORDS)) begin
          state_d     = FS_DONE;
          fill_bank_d = ~fill_bank_q;
        end
      end
      FS_DONE: begin
        state_d = FS_IDLE;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FS_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      ack_cnt_q   <= '0;
      fill_bank_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      fill_bank_q <= fill_bank_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    adr_sum    = addr_q + 32'({issue_cnt_q, 2'b00});
    wb_adr_o   = {adr_sum[31:2], 2'b00};
    wb_cyc_o   = in_cycle;
    wb_stb_o   = (state_q == FS_ISSUE);
    wb_we_o    = 1'b0;
    wb_sel_o   = 4'hf;
    wb_dat_o   = '0;
    busy       = in_cycle;
    line_ready = (state_q == FS_DONE);
    fill_bank  = fill_bank_q;
    overrun    = overrun_q;
  end

  vga_linebuf #(
    .WORDS (WORDS)
  ) u_linebuf (
    .clk_i     (clk_i),
    .wr_en_i   (ack_take),
    .wr_addr_i ({fill_bank_q, ack_cnt_q[AW-1:0]}),
    .wr_data_i (wb_dat_i),
    .pix_clk   (pix_clk),
    .rd_addr_i ({rd_bank, rd_addr}),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a pipelined Wishbone slave model and scoreboard queues.
module tb_vga_line_fetch;

  localparam int unsigned WORDS  = 4;
  localparam int unsigned STRIDE = 16;
  localparam int unsigned LNW    = 10;

  logic        clk = 1'b0;
  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] sdat = '0;
  logic        ack = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] base_addr = '0;
  logic        line_req = 1'b0;
  logic [LNW-1:0] line_num = '0;
  logic        busy, line_ready, fill_bank, overrun;
  logic        rd_bank = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;

  always #5 clk = ~clk;
  always #7 pix_clk = ~pix_clk;

  vga_line_fetch #(
    .WORDS  (WORDS),
    .STRIDE (STRIDE),
    .LNW    (LNW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pix_clk    (pix_clk),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_sel_o   (sel),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat_o),
    .wb_dat_i   (sdat),
    .wb_ack_i   (ack),
    .wb_stall_i (stall),
    .base_addr  (base_addr),
    .line_req   (line_req),
    .line_num   (line_num),
    .busy       (busy),
    .line_ready (line_ready),
    .fill_bank  (fill_bank),
    .overrun    (overrun),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] adr;
  } pend_t;

  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  pend_t       pend_q[$];
  int  lat = 1;
  bit  stall_en = 1'b0;
  int  stall_left = 0;
  int  stall_cyc = 0;
  int  acc_cnt = 0;
  int  cyc_no = 0;
  int  lr_cnt = 0;
  logic prev_busy = 1'b0;
  logic prev_cyc = 1'b0;

  // Slave and monitor: everything is driven/sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      ack = 1'b0;
      stall = 1'b0;
      prev_busy = 1'b0;
      prev_cyc = 1'b0;
    end else begin
      cyc_no++;
      ack = 1'b0;
      stall = stall_en && cyc && stb && (acc_cnt == 1) && (stall_left > 0);
      if (stall) begin
        stall_left--;
        stall_cyc++;
        if (exp_adr_q.size() > 0) check32("adr_during_stall", adr, exp_adr_q[0]);
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc_no) begin
        ack  = 1'b1;
        sdat = slave_data(pend_q[0].adr);
        void'(pend_q.pop_front());
      end
      if (cyc && stb && !stall) begin
        if (exp_adr_q.size() > 0) check32("bus_adr", adr, exp_adr_q.pop_front());
        acc_cnt++;
        pend_q.push_back('{cyc_no + lat, adr});
      end
      if (line_ready) begin
        lr_cnt++;
        check32("busy_at_ready", 32'(busy), 32'd0);
        check32("cyc_at_ready", 32'(cyc), 32'd0);
        check32("cyc_before_ready", 32'(prev_cyc), 32'd1);
        check32("busy_before_ready", 32'(prev_busy), 32'd1);
      end
      prev_busy = busy;
      prev_cyc = cyc;
    end
  end

  task automatic push_line(input logic [31:0] base, input logic [LNW-1:0] ln);
    logic [31:0] a;
    for (int i = 0; i < int'(WORDS); i++) begin
      a = base + 32'(ln) * STRIDE + 32'(4 * i);
      exp_adr_q.push_back(a);
      exp_dat_q.push_back(slave_data(a));
    end
  endtask

  task automatic start_line(input logic [31:0] base, input logic [LNW-1:0] ln);
    push_line(base, ln);
    acc_cnt = 0;
    @(negedge clk);
    base_addr = base;
    line_num = ln;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int start;
    int n;
    start = lr_cnt;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (lr_cnt == start && n < budget);
    check32({tag, "_ready_seen"}, 32'(lr_cnt - start), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check32({tag, "_ready_pulses"}, 32'(lr_cnt - start), 32'd1);
    check32({tag, "_accepts"}, 32'(acc_cnt), WORDS);
  endtask

  task automatic read_line(input string tag, input logic bank);
    for (int i = 0; i < int'(WORDS); i++) begin
      @(negedge pix_clk);
      rd_bank = bank;
      rd_addr = 2'(i);
      @(posedge pix_clk);
      #1;
      check32(tag, rd_data, exp_dat_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check32("rst_cyc", 32'(cyc), 32'd0);
    check32("rst_stb", 32'(stb), 32'd0);
    check32("rst_we", 32'(we), 32'd0);
    check32("rst_sel", 32'(sel), 32'hf);
    check32("rst_adr", adr, 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_line_ready", 32'(line_ready), 32'd0);
    check32("rst_fill_bank", 32'(fill_bank), 32'd0);
    check32("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: zero-wait slave, base 0x1000 line 2 -> 0x1020..0x102c into bank 0.
    check32("t1_first_adr", 32'h1000 + 32'd2 * STRIDE, 32'(32'h1020 + 0 * adr));
    start_line(32'h1000, 10'd2);
    check32("t1_busy_next", 32'(busy), 32'd1);
    wait_ready("t1", 50);
    check32("t1_fill_bank", 32'(fill_bank), 32'd1);
    read_line("t1_rd", 1'b0);

    // 2: three stall cycles on the second request.
    stall_en = 1'b1;
    stall_left = 3;
    stall_cyc = 0;
    start_line(32'h2000, 10'd1);
    wait_ready("t2", 60);
    check32("t2_stall_cycles", 32'(stall_cyc), 32'd3);
    check32("t2_fill_bank", 32'(fill_bank), 32'd0);
    read_line("t2_rd", 1'b1);
    stall_en = 1'b0;

    // 4: second request during ISSUE is dropped and flags overrun.
    start_line(32'h3000, 10'd4);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    #1;
    check32("t4_overrun_set", 32'(overrun), 32'd1);
    wait_ready("t4", 50);
    check32("t4_overrun_sticky", 32'(overrun), 32'd1);
    check32("t4_fill_bank", 32'(fill_bank), 32'd1);
    read_line("t4_rd", 1'b0);

    // 5: asynchronous reset mid-ISSUE, then a request on the release edge.
    push_line(32'h4000, 10'd3);
    acc_cnt = 0;
    @(negedge clk);
    base_addr = 32'h4000;
    line_num = 10'd3;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check32("t5_cyc_async", 32'(cyc), 32'd0);
    check32("t5_stb_async", 32'(stb), 32'd0);
    check32("t5_fill_bank", 32'(fill_bank), 32'd0);
    check32("t5_overrun", 32'(overrun), 32'd0);
    exp_adr_q.delete();
    exp_dat_q.delete();
    push_line(32'h5000, 10'd6);
    acc_cnt = 0;
    @(negedge clk);
    base_addr = 32'h5000;
    line_num = 10'd6;
    line_req = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    line_req = 1'b0;
    wait_ready("t5", 50);
    check32("t5_fill_bank_after", 32'(fill_bank), 32'd1);
    read_line("t5_rd", 1'b0);

    // 3: five-cycle ack latency keeps cyc up through DRAIN.
    lat = 5;
    start_line(32'h6000, 10'd7);
    wait_ready("t3", 60);
    check32("t3_fill_bank", 32'(fill_bank), 32'd0);
    read_line("t3_rd", 1'b1);

    // 6: consecutive lines; bank 0 read back while bank 1 is being filled.
    lat = 1;
    start_line(32'h8000, 10'd5);
    wait_ready("t6a", 50);
    check32("t6a_fill_bank", 32'(fill_bank), 32'd1);
    lat = 8;
    start_line(32'h8000, 10'd9);
    read_line("t6_rd_bank0_during", 1'b0);
    check32("t6_still_busy", 32'(busy), 32'd1);
    wait_ready("t6b", 60);
    check32("t6b_fill_bank", 32'(fill_bank), 32'd0);
    read_line("t6_rd_bank1", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
